add_share_sched: RTL and testbench
==================================

Name: add_share_sched

Overview:
- Round-robin scheduler that shares one add_width-bit adder datapath between NUM_REQ requesters.
- Accepts one operand set per transaction through a valid/ready handshake and drives it onto the shared adder.
- Waits the adder's fixed latency, captures sum/cout and returns them with the requester ID through a valid/ready response port.
- Sits between client blocks and the adder whose outputs are the add_out bus (sum, cout).

Parameters:
add_width, 4, operand/sum width in bits
NUM_REQ, 4, number of requesters (2..8)
ADD_LAT, 1, adder latency in cycles from operands driven to sum/cout valid (1..7)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  NUM_REQ*add_width  operand A, requester i at [i*add_width +: add_width]
req_b  input  NUM_REQ*add_width  operand B, same packing
req_cin  input  NUM_REQ  carry-in per requester
add_a  output  add_width  operand A to shared adder
add_b  output  add_width  operand B to shared adder
add_cin  output  1  carry-in to shared adder
sum  input  add_width  adder sum (add_out bus)
cout  input  1  adder carry-out (add_out bus)
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  clog2(NUM_REQ)  requester ID of response
rsp_sum  output  add_width  captured sum
rsp_cout  output  1  captured carry-out
busy  output  1  high when state != IDLE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, req_ready=0, add_a/add_b/add_cin=0, rsp_valid=0, rsp_id/rsp_sum/rsp_cout=0, busy=0, RR pointer=NUM_REQ-1 (requester 0 wins first), latency counter=0.
- Reset asserted mid-transaction aborts it silently; no response is produced.
- FSM IDLE:
  - If any req_valid, grant the first valid index searching from pointer+1 upward with wrap modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch operands and ID, set pointer=grant, go to BUSY.
  - If no req_valid, stay in IDLE and req_ready=0.
- FSM BUSY:
  - add_a/add_b/add_cin are held at the latched operands for exactly ADD_LAT cycles; counter counts 1..ADD_LAT.
  - At the edge ending cycle ADD_LAT, capture sum/cout into rsp_sum/rsp_cout, then go to RESP.
  - req_ready=0 throughout.
- FSM RESP:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_cout are stable until the handshake.
  - When rsp_valid&rsp_ready, go to IDLE; rsp_valid deasserts next cycle.
  - req_ready=0 in RESP; no accept happens in the handshake cycle.
- Latency: accept at cycle T -> add_* driven T+1..T+ADD_LAT -> rsp_valid at T+ADD_LAT+1 (with rsp_ready=1).
- Throughput: one transaction per ADD_LAT+2 cycles.
- add_a/add_b/add_cin retain their last value outside BUSY; they are not cleared.
- Requesters may drop req_valid before acceptance with no effect. Operands are sampled only in the accept cycle.
- Arithmetic is performed only by the external adder; the block passes sum/cout unmodified (wrap-around is carried by cout).
- A single requester held valid continuously is re-granted each IDLE visit. Others always win over the last grantee when valid (starvation-free; max wait NUM_REQ-1 transactions).
- Simultaneous valids in IDLE: exactly one grant per IDLE cycle, by RR order.

Test Plan:
- Single request, defaults: req 2 sends a=4'hF, b=4'h1, cin=0 with the adder model returning the sum -> req_ready[2] for 1 cycle; add_a=F, add_b=1 for 1 cycle; rsp_valid at T+2 with rsp_id=2, rsp_sum=4'h0, rsp_cout=1.
- Round-robin: all 4 req_valid held high after reset, rsp_ready=1 -> grant order 0,1,2,3,0,1; each grant 3 cycles apart; no req_ready in BUSY/RESP.
- Backpressure: req 1 sends a=4'h7, b=4'h8, cin=1 and rsp_ready is held low 5 cycles -> rsp_valid, rsp_sum=4'h0, rsp_cout=1 stable all 5 cycles; req 3 valid meanwhile gets req_ready only after the handshake plus 1 cycle.
- Latency: ADD_LAT=3, a=4'h5, b=4'h6 -> add_* held 3 cycles; sum captured at the 3rd edge; rsp_valid at T+4 with rsp_sum=4'hB, rsp_cout=0.
- Reset mid-op: rst asserted during BUSY -> immediately rsp_valid=0, busy=0, req_ready=0. After release, req 0 and req 3 both valid -> req 0 granted first.
- Withdrawn request: req 1 valid for 1 cycle while busy then dropped -> never accepted, no response with rsp_id=1.

Source files
------------

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one external adder between NUM_REQ requesters.
// One transaction in flight: accept -> hold operands ADD_LAT cycles -> capture -> respond.
module add_share_sched #(
    parameter int add_width = 4,
    parameter int NUM_REQ   = 4,
    parameter int ADD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*add_width-1:0] req_a,
    input  logic [NUM_REQ*add_width-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_cin,
    output logic [add_width-1:0]         add_a,
    output logic [add_width-1:0]         add_b,
    output logic                         add_cin,
    input  logic [add_width-1:0]         sum,
    input  logic                         cout,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [add_width-1:0]         rsp_sum,
    output logic                         rsp_cout,
    output logic                         busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [add_width-1:0]   add_a_q;
    logic [add_width-1:0]   add_b_q;
    logic                   add_cin_q;
    logic                   rsp_valid_q;
    logic [ID_W-1:0]        rsp_id_q;
    logic [add_width-1:0]   rsp_sum_q;
    logic                   rsp_cout_q;

    logic [add_width-1:0]   a_arr [NUM_REQ];
    logic [add_width-1:0]   b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*add_width +: add_width];
            assign b_arr[gi] = req_b[gi*add_width +: add_width];
        end
    endgenerate

    // Search starts one past the last grantee so every other valid requester wins first.
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    assign req_ready = (state_q == IDLE && grant_found && !rst)
                     ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        add_a_q   <= a_arr[grant_id];
                        add_b_q   <= b_arr[grant_id];
                        add_cin_q <= req_cin[grant_id];
                        rsp_id_q  <= grant_id;
                        ptr_q     <= grant_id;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_W'(ADD_LAT)) begin
                        rsp_sum_q   <= sum;
                        rsp_cout_q  <= cout;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_share_sched.sv
// Bench for add_share_sched: one instance with ADD_LAT=1, one with ADD_LAT=3,
// each wired to an adder model whose result appears ADD_LAT cycles after its operands.
module tb_add_share_sched;
    localparam int W   = 4;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]   req_valid [2];
    logic [NR-1:0]   req_ready [2];
    logic [NR*W-1:0] req_a     [2];
    logic [NR*W-1:0] req_b     [2];
    logic [NR-1:0]   req_cin   [2];
    logic [W-1:0]    add_a     [2];
    logic [W-1:0]    add_b     [2];
    logic            add_cin   [2];
    logic [W-1:0]    sum       [2];
    logic            cout      [2];
    logic            rsp_valid [2];
    logic            rsp_ready [2];
    logic [IDW-1:0]  rsp_id    [2];
    logic [W-1:0]    rsp_sum   [2];
    logic            rsp_cout  [2];
    logic            busy      [2];

    int n_checks = 0;
    int n_errors = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : 3;
            logic [W:0] comb_res;
            assign comb_res = {1'b0, add_a[gi]} + {1'b0, add_b[gi]} + {{W{1'b0}}, add_cin[gi]};

            add_share_sched #(.add_width(W), .NUM_REQ(NR), .ADD_LAT(L)) u_dut (
                .clk(clk), .rst(rst),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
                .req_a(req_a[gi]), .req_b(req_b[gi]), .req_cin(req_cin[gi]),
                .add_a(add_a[gi]), .add_b(add_b[gi]), .add_cin(add_cin[gi]),
                .sum(sum[gi]), .cout(cout[gi]),
                .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]),
                .rsp_id(rsp_id[gi]), .rsp_sum(rsp_sum[gi]), .rsp_cout(rsp_cout[gi]),
                .busy(busy[gi])
            );

            if (L == 1) begin : g_comb
                assign {cout[gi], sum[gi]} = comb_res;
            end else begin : g_pipe
                logic [W:0] dly [L-1];
                always @(posedge clk) begin
                    dly[0] <= comb_res;
                    for (int k = 1; k < L - 1; k++) dly[k] <= dly[k-1];
                end
                assign {cout[gi], sum[gi]} = dly[L-2];
            end
        end
    endgenerate

    typedef struct {
        int         d;
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [NR-1:0] oh(input int id);
        return 4'b0001 << id;
    endfunction

    task automatic cyc_start;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_mid;
        @(negedge clk);
    endtask

    task automatic clear_inputs(input int d);
        req_valid[d] = '0;
        req_a[d]     = 16'($urandom);
        req_b[d]     = 16'($urandom);
        req_cin[d]   = '0;
        rsp_ready[d] = 1'b1;
    endtask

    task automatic set_req(input int d, input int id, input logic [3:0] a,
                           input logic [3:0] b, input logic c);
        req_valid[d] = req_valid[d] | oh(id);
        req_a[d]     = (req_a[d] & ~(16'hF << (id*W))) | (16'(a) << (id*W));
        req_b[d]     = (req_b[d] & ~(16'hF << (id*W))) | (16'(b) << (id*W));
        req_cin[d]   = (req_cin[d] & ~oh(id)) | (c ? oh(id) : 4'b0000);
    endtask

    task automatic do_reset;
        cyc_start;
        rst = 1'b1;
        clear_inputs(0);
        clear_inputs(1);
        cyc_start;
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int L;
        L = lat(v.d);
        cyc_start;
        clear_inputs(v.d);
        set_req(v.d, v.id, v.a, v.b, v.cin);
        cyc_mid;
        chk("vec_accept", 32'(req_ready[v.d]), 32'(oh(v.id)));
        cyc_start;
        clear_inputs(v.d);
        for (int k = 0; k < L; k++) begin
            if (k > 0) cyc_start;
            cyc_mid;
            chk("vec_add_a", 32'(add_a[v.d]), 32'(v.a));
            chk("vec_add_b", 32'(add_b[v.d]), 32'(v.b));
            chk("vec_add_cin", 32'(add_cin[v.d]), 32'(v.cin));
            chk("vec_busy", 32'(busy[v.d]), 32'(1));
            chk("vec_early_rsp", 32'(rsp_valid[v.d]), 32'(0));
            chk("vec_busy_ready", 32'(req_ready[v.d]), 32'(0));
        end
        cyc_start;
        cyc_mid;
        chk("vec_rsp_valid", 32'(rsp_valid[v.d]), 32'(1));
        chk("vec_rsp_id", 32'(rsp_id[v.d]), 32'(v.id));
        chk("vec_rsp_sum", 32'(rsp_sum[v.d]), 32'(v.exp_sum));
        chk("vec_rsp_cout", 32'(rsp_cout[v.d]), 32'(v.exp_cout));
        $display("txn dut%0d id=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d",
                 v.d, v.id, v.a, v.b, v.cin, rsp_sum[v.d], rsp_cout[v.d]);
        cyc_start;
        cyc_mid;
        chk("vec_rsp_drop", 32'(rsp_valid[v.d]), 32'(0));
        chk("vec_idle", 32'(busy[v.d]), 32'(0));
    endtask

    // Reference model state: at most one outstanding transaction per instance.
    bit pend   [2];
    int p_id   [2];
    int p_sum  [2];
    int p_cout [2];
    int p_due  [2];
    int last   [2];

    initial begin
        int order [6];
        int n_rsp, n_id1, win, idx, ra, rb, rc, res;
        logic [NR-1:0] exp_rdy;
        bit exp_rv;

        vecs[0] = '{0, 2, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        vecs[1] = '{0, 1, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
        vecs[2] = '{0, 0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
        vecs[3] = '{0, 3, 4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
        vecs[4] = '{0, 2, 4'h8, 4'h7, 1'b0, 4'hF, 1'b0};
        vecs[5] = '{1, 0, 4'h5, 4'h6, 1'b0, 4'hB, 1'b0};
        vecs[6] = '{1, 3, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[7] = '{1, 1, 4'h9, 4'h3, 1'b1, 4'hD, 1'b0};

        rst = 1'b1;
        clear_inputs(0);
        clear_inputs(1);
        cyc_mid;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'(0));
            chk("rst_busy", 32'(busy[d]), 32'(0));
            chk("rst_add_a", 32'(add_a[d]), 32'(0));
            chk("rst_add_b", 32'(add_b[d]), 32'(0));
            chk("rst_add_cin", 32'(add_cin[d]), 32'(0));
            chk("rst_rsp_id", 32'(rsp_id[d]), 32'(0));
            chk("rst_rsp_sum", 32'(rsp_sum[d]), 32'(0));
            chk("rst_rsp_cout", 32'(rsp_cout[d]), 32'(0));
        end
        cyc_start;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Round-robin with all requesters held valid.
        do_reset;
        order = '{0, 1, 2, 3, 0, 1};
        for (int c = 0; c < 18; c++) begin
            cyc_start;
            if (c == 0) req_valid[0] = 4'hF;
            cyc_mid;
            chk("rr_ready", 32'(req_ready[0]), 32'((c % 3 == 0) ? oh(order[c/3]) : 4'b0000));
            if (c % 3 == 2) begin
                chk("rr_rsp_id", 32'(rsp_id[0]), 32'(order[c/3]));
                $display("txn rr grant=%0d rsp_id=%0d", order[c/3], rsp_id[0]);
            end
        end
        cyc_start;
        clear_inputs(0);

        // Backpressure: response held while req 3 waits.
        do_reset;
        cyc_start;
        set_req(0, 1, 4'h7, 4'h8, 1'b1);
        rsp_ready[0] = 1'b0;
        cyc_mid;
        chk("bp_accept", 32'(req_ready[0]), 32'(oh(1)));
        cyc_start;
        req_valid[0] = '0;
        set_req(0, 3, 4'h2, 4'h3, 1'b0);
        cyc_mid;
        chk("bp_busy_ready", 32'(req_ready[0]), 32'(0));
        for (int k = 0; k < 5; k++) begin
            cyc_start;
            cyc_mid;
            chk("bp_hold_valid", 32'(rsp_valid[0]), 32'(1));
            chk("bp_hold_sum", 32'(rsp_sum[0]), 32'(0));
            chk("bp_hold_cout", 32'(rsp_cout[0]), 32'(1));
            chk("bp_hold_id", 32'(rsp_id[0]), 32'(1));
            chk("bp_hold_ready", 32'(req_ready[0]), 32'(0));
        end
        cyc_start;
        rsp_ready[0] = 1'b1;
        cyc_mid;
        chk("bp_hs_valid", 32'(rsp_valid[0]), 32'(1));
        chk("bp_hs_ready", 32'(req_ready[0]), 32'(0));
        $display("txn bp id=1 sum=%h cout=%0d", rsp_sum[0], rsp_cout[0]);
        cyc_start;
        cyc_mid;
        chk("bp_after_valid", 32'(rsp_valid[0]), 32'(0));
        chk("bp_next_grant", 32'(req_ready[0]), 32'(oh(3)));
        cyc_start;
        req_valid[0] = '0;
        cyc_mid;
        chk("bp_busy2", 32'(busy[0]), 32'(1));
        cyc_start;
        cyc_mid;
        chk("bp_rsp2_id", 32'(rsp_id[0]), 32'(3));
        chk("bp_rsp2_sum", 32'(rsp_sum[0]), 32'(5));
        chk("bp_rsp2_cout", 32'(rsp_cout[0]), 32'(0));
        $display("txn bp id=3 sum=%h cout=%0d", rsp_sum[0], rsp_cout[0]);
        cyc_start;
        clear_inputs(0);

        // Reset during BUSY aborts the transaction.
        do_reset;
        cyc_start;
        set_req(0, 0, 4'h9, 4'h9, 1'b0);
        cyc_mid;
        chk("rm_accept", 32'(req_ready[0]), 32'(oh(0)));
        cyc_start;
        clear_inputs(0);
        cyc_mid;
        chk("rm_busy", 32'(busy[0]), 32'(1));
        #1;
        rst = 1'b1;
        set_req(0, 0, 4'h1, 4'h2, 1'b0);
        set_req(0, 3, 4'h4, 4'h4, 1'b1);
        #1;
        chk("rm_rsp_valid", 32'(rsp_valid[0]), 32'(0));
        chk("rm_busy_clr", 32'(busy[0]), 32'(0));
        chk("rm_ready_clr", 32'(req_ready[0]), 32'(0));
        cyc_start;
        rst = 1'b0;
        cyc_mid;
        chk("rm_first_grant", 32'(req_ready[0]), 32'(oh(0)));
        cyc_start;
        req_valid[0] = 4'b1000;
        cyc_mid;
        chk("rm_busy_ready", 32'(req_ready[0]), 32'(0));
        cyc_start;
        cyc_mid;
        chk("rm_rsp_valid2", 32'(rsp_valid[0]), 32'(1));
        chk("rm_rsp_id", 32'(rsp_id[0]), 32'(0));
        chk("rm_rsp_sum", 32'(rsp_sum[0]), 32'(3));
        $display("txn rm id=0 sum=%h cout=%0d", rsp_sum[0], rsp_cout[0]);
        cyc_start;
        cyc_mid;
        chk("rm_second_grant", 32'(req_ready[0]), 32'(oh(3)));
        cyc_start;
        clear_inputs(0);
        cyc_start;
        cyc_mid;
        chk("rm_rsp3_id", 32'(rsp_id[0]), 32'(3));
        chk("rm_rsp3_sum", 32'(rsp_sum[0]), 32'(9));
        chk("rm_rsp3_cout", 32'(rsp_cout[0]), 32'(0));
        $display("txn rm id=3 sum=%h cout=%0d", rsp_sum[0], rsp_cout[0]);

        // Request withdrawn while the scheduler is busy.
        do_reset;
        cyc_start;
        set_req(0, 0, 4'h2, 4'h2, 1'b0);
        cyc_mid;
        chk("wd_accept", 32'(req_ready[0]), 32'(oh(0)));
        cyc_start;
        req_valid[0] = '0;
        set_req(0, 1, 4'h6, 4'h6, 1'b0);
        cyc_mid;
        chk("wd_busy_ready", 32'(req_ready[0]), 32'(0));
        cyc_start;
        req_valid[0] = '0;
        n_rsp = 0;
        n_id1 = 0;
        for (int c = 0; c < 8; c++) begin
            cyc_mid;
            chk("wd_ready", 32'(req_ready[0]), 32'(0));
            if (rsp_valid[0]) begin
                n_rsp++;
                if (rsp_id[0] == 2'd1) n_id1++;
                $display("txn wd id=%0d sum=%h", rsp_id[0], rsp_sum[0]);
            end
            cyc_start;
        end
        chk("wd_rsp_count", 32'(n_rsp), 32'(1));
        chk("wd_no_id1", 32'(n_id1), 32'(0));

        // Random traffic against a transaction-level model on both instances.
        do_reset;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            last[d] = NR - 1;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            cyc_start;
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                req_a[d]     = 16'($urandom);
                req_b[d]     = 16'($urandom);
                req_cin[d]   = 4'($urandom);
                rsp_ready[d] = ($urandom_range(0, 3) != 0);
            end
            cyc_mid;
            for (int d = 0; d < 2; d++) begin
                win = -1;
                if (!pend[d]) begin
                    for (int k = 1; k <= NR; k++) begin
                        idx = (last[d] + k) % NR;
                        if (win < 0 && ((req_valid[d] >> idx) & 4'b0001) != 4'b0000) win = idx;
                    end
                end
                exp_rdy = (win >= 0) ? oh(win) : 4'b0000;
                exp_rv  = pend[d] && (cyc >= p_due[d]);
                chk("rnd_ready", 32'(req_ready[d]), 32'(exp_rdy));
                chk("rnd_rsp_valid", 32'(rsp_valid[d]), 32'(exp_rv));
                chk("rnd_busy", 32'(busy[d]), 32'(pend[d]));
                if (exp_rv) begin
                    chk("rnd_rsp_id", 32'(rsp_id[d]), 32'(p_id[d]));
                    chk("rnd_rsp_sum", 32'(rsp_sum[d]), 32'(p_sum[d]));
                    chk("rnd_rsp_cout", 32'(rsp_cout[d]), 32'(p_cout[d]));
                    if (rsp_ready[d]) begin
                        $display("txn rnd dut%0d id=%0d sum=%h cout=%0d",
                                 d, rsp_id[d], rsp_sum[d], rsp_cout[d]);
                        pend[d] = 1'b0;
                    end
                end
                if (win >= 0) begin
                    ra = int'((req_a[d] >> (win*W)) & 16'hF);
                    rb = int'((req_b[d] >> (win*W)) & 16'hF);
                    rc = int'((req_cin[d] >> win) & 4'b0001);
                    res       = ra + rb + rc;
                    pend[d]   = 1'b1;
                    p_id[d]   = win;
                    p_sum[d]  = res % 16;
                    p_cout[d] = res / 16;
                    p_due[d]  = cyc + lat(d) + 1;
                    last[d]   = win;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
